pwm_ramp_sequencer: RTL and testbench

- Drives the LED brightness PWM for the front panel; sits between the UI logic (rotary encoder and button decode) and the `led` outputs.
- Accepts a target duty cycle and a frequency select from the UI.
- Ramps the applied duty toward the target in fixed steps and applies every duty or frequency change only at a PWM period boundary, so the output never glitches.
- Exposes the applied duty and a busy flag so the LCD text logic can show live values.

---
 rtl/pwm_ramp_sequencer.sv | 133 +++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// Front-panel LED PWM with period-aligned duty ramping and frequency select.
// Ports: clk, reset (sync, active-high); target_duty/target_valid set the
// goal duty; freq_sel picks slot length; pwm_out, cur_duty, busy, period_start
// report the applied waveform and ramp status.
module pwm_ramp_sequencer #(
  parameter int TICKS_SLOW   = 20000,
  parameter int TICKS_FAST   = 5000,
  parameter int STEP         = 5,
  parameter int RAMP_PERIODS = 2,
  parameter int RESET_DUTY   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] target_duty,
  input  logic       target_valid,
  input  logic       freq_sel,
  output logic       pwm_out,
  output logic [6:0] cur_duty,
  output logic       busy,
  output logic       period_start
);

  localparam int RCW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [15:0]    TS_LAST = 16'(TICKS_SLOW - 1);
  localparam logic [15:0]    TF_LAST = 16'(TICKS_FAST - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RAMP_PERIODS - 1);
  localparam logic [7:0]     STEP8   = 8'(STEP);
  localparam logic [6:0]     RST_D   = 7'(RESET_DUTY);

  typedef enum logic {
    IDLE,
    RAMP
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    tick_q, tick_d;
  logic [6:0]     slot_q, slot_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [6:0]     cur_q, cur_d;
  logic [6:0]     tgt_q, tgt_d;
  logic           sel_q, sel_d;
  logic           pwm_q, ps_q;

  logic       tick_last;
  logic       bnd;
  logic [6:0] tgt_clamp;
  logic [7:0] cur8, tgt8, up8;
  logic [6:0] stepped;

  assign tick_last = (tick_q == (sel_q ? TF_LAST : TS_LAST));
  assign bnd       = tick_last && (slot_q == 7'd99);
  assign tgt_clamp = (target_duty > 7'd100) ? 7'd100 : target_duty;

  // Step toward tgt, saturating on tgt in either direction.
  assign cur8 = {1'b0, cur_q};
  assign tgt8 = {1'b0, tgt_q};
  assign up8  = cur8 + STEP8;

  always_comb begin
    stepped = tgt_q;
    if (tgt8 > cur8) begin
      if (up8 < tgt8) stepped = up8[6:0];
    end else if (cur8 >= tgt8 + STEP8) begin
      stepped = 7'(cur8 - STEP8);
    end
  end

  always_comb begin
    tick_d  = tick_last ? 16'd0 : tick_q + 16'd1;
    slot_d  = slot_q;
    if (tick_last) slot_d = (slot_q == 7'd99) ? 7'd0 : slot_q + 7'd1;
    sel_d   = bnd ? freq_sel : sel_q;
    tgt_d   = target_valid ? tgt_clamp : tgt_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cur_d   = cur_q;
    // Ramp decisions use the tgt held before any same-cycle strobe.
    if (bnd) begin
      unique case (state_q)
        IDLE: begin
          if (tgt_q != cur_q) begin
            state_d = RAMP;
            rcnt_d  = '0;
          end
        end
        RAMP: begin
          unique case (1'b1)
            (tgt_q == cur_q): state_d = IDLE;
            (rcnt_q == RC_LAST): begin
              rcnt_d = '0;
              cur_d  = stepped;
              if (stepped == tgt_q) state_d = IDLE;
            end
            default: rcnt_d = rcnt_q + 1'b1;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      slot_q  <= '0;
      rcnt_q  <= '0;
      cur_q   <= RST_D;
      tgt_q   <= RST_D;
      sel_q   <= 1'b0;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      slot_q  <= slot_d;
      rcnt_q  <= rcnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      pwm_q   <= (slot_q < cur_q);
      // Counters wrap to tick=0/slot=0 right after a boundary.
      ps_q    <= bnd;
    end
  end

  assign pwm_out      = pwm_q;
  assign cur_duty     = cur_q;
  assign busy         = (state_q == RAMP);
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Testbench for pwm_ramp_sequencer: directed table, hand sequences and a
// randomized phase checked against a position-based reference model.
module tb_pwm_ramp_sequencer;

  localparam int TS = 4;
  localparam int TF = 1;
  localparam int ST = 5;
  localparam int RP = 2;
  localparam int RD = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] target_duty = '0;
  logic       target_valid = 1'b0;
  logic       freq_sel = 1'b0;
  logic       pwm_out;
  logic [6:0] cur_duty;
  logic       busy;
  logic       period_start;

  pwm_ramp_sequencer #(
    .TICKS_SLOW(TS), .TICKS_FAST(TF), .STEP(ST),
    .RAMP_PERIODS(RP), .RESET_DUTY(RD)
  ) dut (
    .clk(clk), .reset(reset),
    .target_duty(target_duty), .target_valid(target_valid),
    .freq_sel(freq_sel), .pwm_out(pwm_out), .cur_duty(cur_duty),
    .busy(busy), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: position within the period, duty ramp by rule.
  int mpos = 0, msel = 0, mcur = RD, mtgt = RD, mbusy = 0, mrc = 0;
  int mpwm = 0, mps = 0, mT = TS;
  bit mbnd;

  always @(posedge clk) begin
    if (reset) begin
      mpos = 0; msel = 0; mcur = RD; mtgt = RD;
      mbusy = 0; mrc = 0; mpwm = 0; mps = 0;
    end else begin
      mT = msel ? TF : TS;
      mbnd = (mpos == 100 * mT - 1);
      mpwm = ((mpos / mT) < mcur) ? 1 : 0;
      mps = mbnd ? 1 : 0;
      if (mbnd) begin
        if (!mbusy) begin
          if (mtgt != mcur) begin mbusy = 1; mrc = 0; end
        end else if (mtgt == mcur) begin
          mbusy = 0;
        end else if (mrc == RP - 1) begin
          mrc = 0;
          if (mtgt > mcur) mcur = (mcur + ST > mtgt) ? mtgt : mcur + ST;
          else mcur = (mcur - ST < mtgt) ? mtgt : mcur - ST;
          if (mcur == mtgt) mbusy = 0;
        end else begin
          mrc++;
        end
        msel = freq_sel;
        mpos = 0;
      end else begin
        mpos++;
      end
      if (target_valid) mtgt = (target_duty > 100) ? 100 : int'(target_duty);
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("cycle{pwm,ps,busy,duty}",
          {pwm_out, period_start, busy, cur_duty},
          {mpwm[0], mps[0], mbusy[0], mcur[6:0]});
  end

  task automatic wait_ps(input int n);
    int seen = 0;
    int lim = n * 400 + 50;
    while (seen < n && lim > 0) begin
      @(negedge clk);
      lim--;
      if (period_start) seen++;
    end
    if (seen < n) chk("wait_ps_timeout", seen, n);
  endtask

  // Cycles until the next period_start, plus pwm-high count over them.
  task automatic gap(output int n, output int hi);
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm_out) hi++;
    end while (!period_start && n < 1000);
  endtask

  task automatic do_reset(input bit with_strobe);
    reset = 1'b1;
    target_valid = with_strobe;
    target_duty = 7'd10;
    @(negedge clk);
    chk("rst_duty", cur_duty, 100);
    chk("rst_busy", busy, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    reset = 1'b0;
    target_valid = 1'b0;
  endtask

  task automatic strobe(input int d);
    target_valid = 1'b1;
    target_duty = 7'(d);
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  typedef struct {
    bit rst;
    bit vld;
    int duty;
    int nb;
    int exp_duty;
    bit exp_busy;
  } vec_t;

  vec_t tbl[20];

  task automatic run_vec(input int i);
    if (tbl[i].rst) do_reset(0);
    if (tbl[i].vld) strobe(tbl[i].duty);
    wait_ps(tbl[i].nb);
    chk($sformatf("vec%0d_duty", i), cur_duty, tbl[i].exp_duty);
    chk($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
  endtask

  initial begin
    int n, hi;
    tbl[0]  = '{0, 1, 90,  1, 100, 1};
    tbl[1]  = '{0, 0, 0,   1, 100, 1};
    tbl[2]  = '{0, 0, 0,   1, 95,  1};
    tbl[3]  = '{0, 0, 0,   1, 95,  1};
    tbl[4]  = '{0, 0, 0,   1, 90,  0};
    tbl[5]  = '{0, 1, 127, 1, 90,  1};
    tbl[6]  = '{0, 0, 0,   2, 95,  1};
    tbl[7]  = '{0, 0, 0,   2, 100, 0};
    tbl[8]  = '{0, 1, 3,   1, 100, 1};
    tbl[9]  = '{0, 0, 0,   2, 95,  1};
    tbl[10] = '{0, 0, 0,   36, 5,  1};
    tbl[11] = '{0, 0, 0,   2, 3,   0};
    tbl[12] = '{1, 1, 50,  1, 100, 1};
    tbl[13] = '{0, 0, 0,   2, 95,  1};
    tbl[14] = '{0, 0, 0,   4, 85,  1};
    tbl[15] = '{0, 0, 0,   2, 80,  1};
    tbl[16] = '{0, 1, 90,  2, 85,  1};
    tbl[17] = '{0, 0, 0,   2, 90,  0};
    tbl[18] = '{0, 1, 50,  1, 90,  1};
    tbl[19] = '{0, 0, 0,   8, 70,  1};

    do_reset(0);
    chk_en = 1;
    gap(n, hi);
    chk("first_period_len", n, 400);
    chk("first_period_pwm_hi", hi, 400);
    gap(n, hi);
    chk("second_period_len", n, 400);

    for (int i = 0; i < 5; i++) run_vec(i);
    gap(n, hi);
    chk("duty90_pwm_hi", hi, 360);
    chk("duty90_len", n, 400);
    for (int i = 5; i < 20; i++) run_vec(i);

    // Reset mid-ramp with a simultaneous strobe that must be ignored.
    repeat (37) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    do_reset(1);
    gap(n, hi);
    chk("post_rst_period_len", n, 400);
    wait_ps(2);
    chk("post_rst_duty", cur_duty, 100);
    chk("post_rst_busy", busy, 0);

    // Frequency switch at slot 40 must not disturb the current period.
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 160) freq_sel = 1'b1;
    end while (!period_start && n < 1000);
    chk("switch_period_len", n, 400);
    gap(n, hi);
    chk("fast_period_len", n, 100);
    freq_sel = 1'b0;
    gap(n, hi);
    chk("fast_tail_len", n, 100);
    gap(n, hi);
    chk("slow_again_len", n, 400);

    // Randomized phase against the model.
    freq_sel = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 4999) == 0);
      target_valid = ($urandom_range(0, 299) == 0);
      target_duty = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2999) == 0) freq_sel = ~freq_sel;
    end
    @(negedge clk);
    reset = 1'b0;
    target_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
